serial_deserializer: RTL

Receive-side counterpart of the team's 4-bit universal shift register. It collects a serial bit stream, qualified by a per-bit strobe, into WIDTH-bit parallel words. Bit order is selectable per frame: LSB-first (right-shift fill) or MSB-first (left-shift fill). Each completed word is held in a one-entry output buffer with a valid/ready handshake and sticky overrun detection. It sits between a serial link or shift-register serializer and parallel consumer logic.

---
 rtl/serial_deserializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer: collects strobed serial bits into WIDTH-bit words,
// LSB-first or MSB-first per frame, with a one-entry valid/ready output
// buffer and a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for a START bit; non-START bits are ignored
// RECV  | frame in progress, collecting bits until the word completes
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SERIN,
  input  logic             SERVALID,
  input  logic             START,
  input  logic             DIRECTION,
  input  logic             DATAREADY,
  input  logic             OVRCLR,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             DATAVALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             ovr_nxt;

  logic             accept;
  logic             dir_eff;
  logic [CW-1:0]    cnt_base;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             buf_free;

  // State, shift register and output buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      DATAOUT   <= '0;
      DATAVALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      DATAOUT   <= data_nxt;
      DATAVALID <= valid_nxt;
      OVERRUN   <= ovr_nxt;
    end
  end

  // Bit acceptance, shifting, word completion and buffer/overrun updates.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    data_nxt  = DATAOUT;
    valid_nxt = DATAVALID;
    ovr_nxt   = OVERRUN;

    accept   = SERVALID && (START || (state == RECV));
    // A START bit both selects the order and restarts the count, so a
    // mid-frame START simply begins a new frame with this bit.
    dir_eff  = START ? DIRECTION : dir;
    cnt_base = START ? '0 : cnt;
    shifted  = dir_eff ? {sr[WIDTH-2:0], SERIN} : {SERIN, sr[WIDTH-1:1]};
    complete = accept && (cnt_base == CNT_LAST);
    buf_free = !DATAVALID || DATAREADY;

    if (accept) begin
      sr_nxt  = shifted;
      dir_nxt = dir_eff;
      if (complete) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = RECV;
        cnt_nxt   = cnt_base + CW'(1);
      end
    end

    if (complete && buf_free) begin
      data_nxt  = shifted;
      valid_nxt = 1'b1;
    end else if (DATAVALID && DATAREADY) begin
      valid_nxt = 1'b0;
    end

    // A fresh overrun takes priority over a clear at the same edge.
    if (complete && !buf_free) begin
      ovr_nxt = 1'b1;
    end else if (OVRCLR) begin
      ovr_nxt = 1'b0;
    end
  end

  assign BUSY = (state == RECV);

endmodule
